// File: rtl/serial_add_sched.sv
// serial_add_sched: one 1-bit full-adder slice shared round-robin between two requesters, LSB first.
// Define SERIAL_ADD_OVF_EN to add the out_ovf signed-overflow output.
module serial_add_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0_a,
    input  logic [WIDTH-1:0] in0_b,
    input  logic             in0_cin,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in1_a,
    input  logic [WIDTH-1:0] in1_b,
    input  logic             in1_cin,
    input  logic             in1_valid,
    output logic             in1_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_id,
`ifdef SERIAL_ADD_OVF_EN
    output logic             out_ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [IDX_W-1:0] bit_idx;
    logic             op_id;
    logic             last_grant;

    logic             bit_sum;
    logic             bit_carry;
    logic             grant;
    logic             any_valid;
    logic             last_bit;

    assign in0_ready = (state == IDLE);
    assign in1_ready = (state == IDLE);

    // Shared slice works on the LSB of the shifting operand registers.
    always_comb begin
        bit_sum   = a_sh[0] ^ b_sh[0] ^ carry;
        bit_carry = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        any_valid = in0_valid | in1_valid;
        grant     = (in0_valid && in1_valid) ? ~last_grant : in1_valid;
        last_bit  = (bit_idx == IDX_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            sum_sh     <= '0;
            carry      <= 1'b0;
            bit_idx    <= '0;
            op_id      <= 1'b0;
            last_grant <= 1'b1;
            out_sum    <= '0;
            out_cout   <= 1'b0;
            out_id     <= 1'b0;
            out_valid  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            out_ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        a_sh       <= grant ? in1_a : in0_a;
                        b_sh       <= grant ? in1_b : in0_b;
                        carry      <= grant ? in1_cin : in0_cin;
                        op_id      <= grant;
                        last_grant <= grant;
                        bit_idx    <= '0;
                        state      <= ADD;
                    end
                end
                ADD: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    sum_sh  <= {bit_sum, sum_sh[WIDTH-1:1]};
                    carry   <= bit_carry;
                    bit_idx <= bit_idx + 1'b1;
                    // Results are published straight from the final slice so DONE needs no extra cycle.
                    if (last_bit) begin
                        out_sum   <= {bit_sum, sum_sh[WIDTH-1:1]};
                        out_cout  <= bit_carry;
                        out_id    <= op_id;
                        out_valid <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
                        out_ovf   <= carry ^ bit_carry;
`endif
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sched.sv
// Self-checking bench for serial_add_sched: scoreboard of expected results popped as outputs are accepted.
// Define SERIAL_ADD_OVF_EN to also check out_ovf.
module tb_serial_add_sched;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] in0_a, in0_b, in1_a, in1_b;
    logic         in0_cin, in0_valid, in0_ready;
    logic         in1_cin, in1_valid, in1_ready;
    logic [W-1:0] out_sum;
    logic         out_cout, out_id, out_valid, out_ready;
`ifdef SERIAL_ADD_OVF_EN
    logic         out_ovf;
`endif

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         id;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   tb_last = 1'b1;

    serial_add_sched #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in0_a(in0_a), .in0_b(in0_b), .in0_cin(in0_cin), .in0_valid(in0_valid), .in0_ready(in0_ready),
        .in1_a(in1_a), .in1_b(in1_b), .in1_cin(in1_cin), .in1_valid(in1_valid), .in1_ready(in1_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_id(out_id),
`ifdef SERIAL_ADD_OVF_EN
        .out_ovf(out_ovf),
`endif
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic id);
        exp_t        e;
        logic [W:0]  full;
        full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.id   = id;
        e.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return e;
    endfunction

    // Every accepted result is compared against the oldest prediction.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL result_unexpected got sum=%h cout=%b id=%b with empty scoreboard", out_sum, out_cout, out_id);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({out_sum, out_cout, out_id} !== {e.sum, e.cout, e.id}) begin
                    errors++;
                    $display("[TB] FAIL result got sum=%h cout=%b id=%b expected sum=%h cout=%b id=%b",
                             out_sum, out_cout, out_id, e.sum, e.cout, e.id);
                end
`ifdef SERIAL_ADD_OVF_EN
                checks++;
                if (out_ovf !== e.ovf) begin
                    errors++;
                    $display("[TB] FAIL ovf got %b expected %b", out_ovf, e.ovf);
                end
`endif
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        tb_last = 1'b1;
    endtask

    task automatic issue0(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input bit push);
        int guard;
        @(posedge clk); #1;
        in0_a = a; in0_b = b; in0_cin = cin; in0_valid = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!in0_ready && guard < 200);
        if (!in0_ready) begin
            checks++; errors++;
            $display("[TB] FAIL issue0_timeout got ready=%b expected 1", in0_ready);
        end
        if (push) sb.push_back(model(a, b, cin, 1'b0));
        tb_last = 1'b0;
        @(posedge clk); #1;
        in0_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_timeout got pending=%0d expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, in0_ready, in1_ready, out_sum, out_cout, out_id} !== {1'b0, 1'b1, 1'b1, {W{1'b0}}, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_outputs got valid=%b rdy=%b%b sum=%h cout=%b id=%b expected 0 11 00 0 0",
                     out_valid, in0_ready, in1_ready, out_sum, out_cout, out_id);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        tb_last = 1'b1;
    endtask

    task automatic test_single();
        bit early = 1'b0;
        @(posedge clk); #1;
        in0_a = 8'h0F; in0_b = 8'h01; in0_cin = 1'b0; in0_valid = 1'b1;
        sb.push_back(model(8'h0F, 8'h01, 1'b0, 1'b0));
        tb_last = 1'b0;
        @(posedge clk); #1;
        in0_valid = 1'b0;
        checks++;
        if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_ready_low got %b%b expected 00", in0_ready, in1_ready);
        end
        for (int i = 1; i < W; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early) begin
            errors++;
            $display("[TB] FAIL single_latency_early got out_valid=1 expected 0 before cycle %0d", W + 1);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_latency got out_valid=%b expected 1", out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in0_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_return_idle got valid=%b ready=%b expected 0 1", out_valid, in0_ready);
        end
        wait_drain();
    endtask

    task automatic test_round_robin(input int n_ops);
        int served = 0;
        int guard  = 0;
        bit g;
        apply_reset();
        @(posedge clk); #1;
        in0_a = 8'h0F; in0_b = 8'h01; in0_cin = 1'b0;
        in1_a = 8'hFF; in1_b = 8'h01; in1_cin = 1'b1;
        in0_valid = 1'b1; in1_valid = 1'b1;
        while (served < n_ops && guard < 1000) begin
            @(negedge clk);
            guard++;
            if (in0_ready) begin
                g = ~tb_last;
                sb.push_back(g ? model(in1_a, in1_b, in1_cin, 1'b1) : model(in0_a, in0_b, in0_cin, 1'b0));
                tb_last = g;
                served++;
                @(posedge clk); #1;
                if (g) begin
                    in1_a = W'($urandom); in1_b = W'($urandom); in1_cin = 1'($urandom);
                end else begin
                    in0_a = W'($urandom); in0_b = W'($urandom); in0_cin = 1'($urandom);
                end
            end
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
        checks++;
        if (served != n_ops) begin
            errors++;
            $display("[TB] FAIL rr_timeout got served=%0d expected %0d", served, n_ops);
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   guard = 0;
        bit   bad   = 1'b0;
        e = model(8'h3C, 8'h55, 1'b1, 1'b0);
        out_ready = 1'b0;
        issue0(8'h3C, 8'h55, 1'b1, 1'b1);
        in1_valid = 1'b1;
        while (!out_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || out_sum !== e.sum || out_id !== e.id || in0_ready !== 1'b0 || in1_ready !== 1'b0)
                bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("[TB] FAIL backpressure_hold got valid=%b sum=%h id=%b rdy=%b%b expected 1 %h %b 00",
                     out_valid, out_sum, out_id, in0_ready, in1_ready, e.sum, e.id);
        end
        in1_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in0_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== e.sum) begin
            errors++;
            $display("[TB] FAIL backpressure_release got rdy=%b valid=%b sum=%h expected 1 0 %h",
                     in0_ready, out_valid, out_sum, e.sum);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid_add();
        bit seen = 1'b0;
        issue0(8'hA5, 8'h5A, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in0_ready !== 1'b1 || out_sum !== '0) begin
            errors++;
            $display("[TB] FAIL midadd_reset got valid=%b ready=%b sum=%h expected 0 1 00", out_valid, in0_ready, out_sum);
        end
        @(negedge clk);
        in0_a = 8'h22; in0_b = 8'h33; in0_cin = 1'b1; in0_valid = 1'b1;
        rst_n   = 1'b1;
        tb_last = 1'b0;
        sb.push_back(model(8'h22, 8'h33, 1'b1, 1'b0));
        @(posedge clk); #1;
        in0_valid = 1'b0;
        checks++;
        if (in0_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL first_edge_accept got ready=%b expected 0", in0_ready);
        end
        for (int i = 1; i < W; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("[TB] FAIL aborted_op_valid got out_valid=1 expected 0");
        end
        wait_drain();
    endtask

    task automatic test_overflow();
        issue0(8'h7F, 8'h01, 1'b0, 1'b1);
        wait_drain();
        issue0(8'hFF, 8'h01, 1'b0, 1'b1);
        wait_drain();
        issue0(8'h80, 8'h80, 1'b0, 1'b1);
        wait_drain();
    endtask

    initial begin
        rst_n = 1'b1;
        in0_a = '0; in0_b = '0; in0_cin = 1'b0; in0_valid = 1'b0;
        in1_a = '0; in1_b = '0; in1_cin = 1'b0; in1_valid = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin(2);
        test_round_robin(6);
        test_backpressure();
        test_reset_mid_add();
        test_overflow();
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
